approx_multiplier_4x4: RTL and testbench
========================================

# approx_multiplier_4x4

Registered, unsigned 4×4 approximate multiplier producing an 8-bit product. The low-weight partial-product columns are reduced with carry-free OR logic and the high-weight columns are summed exactly, which trades a small, bounded error for a shorter carry chain. It is used as an arithmetic leaf in error-tolerant datapaths, and in error-characterisation benches that sweep all operand pairs and compute mean relative error.

## Interface
- APPROX_COLS, default 3: number of low partial-product columns (weights 2^0 … 2^(APPROX_COLS-1)) reduced by OR. Legal range 0..7; 0 gives an exact multiplier.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A and B are sampled on this edge when high.
- A  input  4  unsigned multiplicand.
- B  input  4  unsigned multiplier.
- out_valid  output  1  P holds the result of an accepted operand pair.
- P  output  8  unsigned approximate product.

## Operation
- Partial products: pp[i][j] = A[j] & B[i], for i, j in 0..3, with weight 2^(i+j). Column k holds every pp with i+j = k, for k in 0..6.
- Low part, columns k < APPROX_COLS:
  - L[k] = OR of all pps in column k.
  - No carry is generated and none propagates out of these columns.
- High part, columns k ≥ APPROX_COLS:
  - H = exact sum of pp·2^(i+j) over those pps, using an adder tree of half and full adders.
  - H is a multiple of 2^APPROX_COLS and ≤ 225, so it always fits in 8 bits.
- Result: P = H | L. The two fields never overlap, so OR is equivalent to addition.
- Error properties:
  - Approximate P ≤ exact A·B for all inputs; the error never overestimates.
  - P is exact whenever no low column holds two or more set partial products.
  - With A=0 or B=0, P=0.
  - With A=1 or B=1, P is exact.
- The combinational core is purely a function of the registered operands. There is no internal state apart from the output registers.

## Timing
- Reset (rst_n low, asynchronous):
  - P = 8'h00 and out_valid = 0 immediately, held while rst_n is low.
  - Release takes effect at the next rising clk edge. Reset asserted mid-stream discards the in-flight result.
- Latency is exactly 1 cycle. When in_valid=1 at edge N, P and out_valid=1 reflect that A/B pair after edge N.
- Throughput is one operation per cycle. Back-to-back in_valid produces back-to-back results with no bubbles.
- When in_valid=0 at an edge, out_valid goes to 0 and P holds its previous value.
- There is no backpressure; the output is overwritten on every accepted input.
- The combinational path runs from the A/B pins through the pp array and adder tree to the P register, within one clock period.

## Test plan
- Reset: drive rst_n=0 with A=15, B=15, in_valid=1 → P=0 and out_valid=0 asynchronously. After release and one edge → P=215, out_valid=1.
- Approximation corner cases (APPROX_COLS=3), each value visible one cycle after issue:
  - 15×15 → 215 (exact 225)
  - 7×7 → 39 (exact 49)
  - 3×3 → 7 (exact 9)
- Exact cases (APPROX_COLS=3):
  - 5×3 → 15
  - 2×3 → 6
  - 8×8 → 64
  - 1×13 → 13
  - 0×9 → 0
- Full sweep: issue all 256 pairs back-to-back, with A = counter[7:4] and B = counter[3:0].
  - Each P must equal the bit-level golden model (OR in low columns, exact sum in high columns).
  - P ≤ A·B for every pair.
  - Mean relative error must be reported, computed as the sum of |P−A·B|/(A·B) over pairs with nonzero product, divided by 256, ×100%.
- Handshake: in_valid pattern 1,0,1 with pairs (3,3) and then (15,15) → out_valid pattern 1,0,1. P = 7, then held at 7, then 215.
- Parameter: APPROX_COLS=0, full sweep → P = A·B for every pair, and mean relative error = 0.00%.

Source files
------------

// File: rtl/approx_multiplier_4x4.sv
// approx_multiplier_4x4
// Registered unsigned 4x4 approximate multiplier. Partial-product columns
// below APPROX_COLS are collapsed with OR (no carries); the remaining
// columns are summed exactly by a ripple array of full/half adders.
// The low field and the high sum occupy disjoint bits, so P = H | L.
//
// Handshake: valid-only, no ready. A/B are accepted on every rising edge
// where in_valid is high; out_valid is high for exactly the cycle after an
// accepted pair and P carries its result. With in_valid low, out_valid
// drops and P keeps its previous value. There is no backpressure.

module approx_multiplier_4x4 #(
  parameter int APPROX_COLS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       out_valid,
  output logic [7:0] P
);

  // Low columns: one OR-reduced bit per column, weight 2^k.
  logic [7:0] low_bits;
  // High columns: partial-product rows with low-column bits masked off.
  logic [3:0] hi_row [4];
  // Exact sum of the masked rows.
  logic [7:0] high_sum;
  logic [7:0] next_p;

  // Build the partial-product array, splitting each pp into low (OR) or high (sum).
  always_comb begin
    low_bits = '0;
    for (int i = 0; i < 4; i++) begin
      hi_row[i] = '0;
      for (int j = 0; j < 4; j++) begin
        if ((i + j) < APPROX_COLS) begin
          low_bits[3'(i + j)] = low_bits[3'(i + j)] | (A[j] & B[i]);
        end else begin
          hi_row[i][j] = A[j] & B[i];
        end
      end
    end
  end

  // Accumulate the shifted high rows with a ripple array of full adders
  // (a full adder with a zero carry-in is the half-adder case).
  always_comb begin
    logic [7:0] acc;
    logic [7:0] addend;
    logic       carry;
    logic       s_bit;
    logic       c_bit;
    acc = {4'b0000, hi_row[0]};
    for (int r = 1; r < 4; r++) begin
      addend = 8'({4'b0000, hi_row[r]} << r);
      carry  = 1'b0;
      for (int b = 0; b < 8; b++) begin
        s_bit  = acc[b] ^ addend[b] ^ carry;
        c_bit  = (acc[b] & addend[b]) | (carry & (acc[b] ^ addend[b]));
        acc[b] = s_bit;
        carry  = c_bit;
      end
    end
    high_sum = acc;
  end

  // Fields never overlap, so OR merges them without a carry.
  always_comb begin
    next_p = high_sum | low_bits;
  end

  // Output registers: capture on accepted input, hold P otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      P         <= 8'h00;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      P         <= next_p;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_approx_multiplier_4x4.sv
// Bench for approx_multiplier_4x4: two instances (APPROX_COLS=3 and 0)
// share the stimulus; a column-count reference model predicts both.

module tb_approx_multiplier_4x4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       valid3, valid0;
  logic [7:0] p3, p0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Clock and reset block
  always #5 clk = ~clk;

  approx_multiplier_4x4 #(.APPROX_COLS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(valid3), .P(p3)
  );

  approx_multiplier_4x4 #(.APPROX_COLS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(valid0), .P(p0)
  );

  // Reference: count set pps per column; OR the count into low columns,
  // add count * 2^k for high columns.
  function automatic logic [7:0] model_p(input int a, input int b, input int ac);
    int h;
    int l;
    int cnt;
    h = 0;
    l = 0;
    for (int k = 0; k < 7; k++) begin
      cnt = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if ((i + j) == k && ((a >> j) & 1) == 1 && ((b >> i) & 1) == 1) cnt++;
      if (k < ac) begin
        if (cnt > 0) l = l | (1 << k);
      end else begin
        h = h + (cnt << k);
      end
    end
    return 8'(h | l);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scoreboard state: expected output registers of both instances
  logic       m_valid;
  logic [7:0] m_p3, m_p0;
  logic [3:0] m_a, m_b;
  logic       m_sweep;
  logic       sweep_on = 1'b0;
  logic       cmp_en   = 1'b0;
  logic [7:0] exp_q[$];
  real        err3 = 0.0;
  real        err0 = 0.0;
  int         sweep_cnt = 0;

  // Model update from the operands sampled at each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_p3    <= 8'h00;
      m_p0    <= 8'h00;
      m_a     <= 4'h0;
      m_b     <= 4'h0;
      m_sweep <= 1'b0;
    end else if (in_valid) begin
      m_valid <= 1'b1;
      m_p3    <= model_p(A, B, 3);
      m_p0    <= model_p(A, B, 0);
      m_a     <= A;
      m_b     <= B;
      m_sweep <= sweep_on;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: every falling edge, away from the active edge
  always @(negedge clk) begin
    int prod;
    if (cmp_en) begin
      check("valid3", {7'b0, valid3}, {7'b0, m_valid});
      check("valid0", {7'b0, valid0}, {7'b0, m_valid});
      check("p3", p3, m_p3);
      check("p0", p0, m_p0);
      if (m_valid) begin
        prod = int'(m_a) * int'(m_b);
        check("p3_le_exact", {7'b0, (int'(p3) <= prod)}, 8'd1);
        if (m_sweep) begin
          sweep_cnt++;
          if (prod != 0) begin
            err3 += ((int'(p3) > prod) ? real'(int'(p3) - prod) : real'(prod - int'(p3))) / real'(prod);
            err0 += ((int'(p0) > prod) ? real'(int'(p0) - prod) : real'(prod - int'(p0))) / real'(prod);
          end
        end
      end
    end
  end

  // Driver: present one operand pair for the next edge
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = v;
    A = a;
    B = b;
  endtask

  // Directed op: result visible one cycle after issue
  task automatic op_check(input string name, input logic [3:0] a, input logic [3:0] b);
    drive(1'b1, a, b);
    @(posedge clk);
    #1;
    check({name, "_valid"}, {7'b0, valid3}, 8'd1);
    check(name, p3, exp_q.pop_front());
  endtask

  initial begin
    // Reset with live operands: outputs must stay cleared
    rst_n = 1'b0;
    in_valid = 1'b1;
    A = 4'd15;
    B = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p3", p3, 8'd0);
    check("rst_valid3", {7'b0, valid3}, 8'd0);
    check("rst_p0", p0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_p3", p3, 8'd215);
    check("post_rst_valid3", {7'b0, valid3}, 8'd1);
    check("post_rst_p0", p0, 8'd225);

    // Pin the model with hand-computed values
    check("model_15x15", model_p(15, 15, 3), 8'd215);
    check("model_7x7", model_p(7, 7, 3), 8'd39);
    check("model_3x3", model_p(3, 3, 3), 8'd7);
    check("model_5x3", model_p(5, 3, 3), 8'd15);
    check("model_15x15_exact", model_p(15, 15, 0), 8'd225);

    // Directed literal cases against the DUT
    exp_q.push_back(8'd215); op_check("lit_15x15", 4'd15, 4'd15);
    exp_q.push_back(8'd39);  op_check("lit_7x7",   4'd7,  4'd7);
    exp_q.push_back(8'd7);   op_check("lit_3x3",   4'd3,  4'd3);
    exp_q.push_back(8'd15);  op_check("lit_5x3",   4'd5,  4'd3);
    exp_q.push_back(8'd6);   op_check("lit_2x3",   4'd2,  4'd3);
    exp_q.push_back(8'd64);  op_check("lit_8x8",   4'd8,  4'd8);
    exp_q.push_back(8'd13);  op_check("lit_1x13",  4'd1,  4'd13);
    exp_q.push_back(8'd0);   op_check("lit_0x9",   4'd0,  4'd9);

    // Handshake 1,0,1
    drive(1'b1, 4'd3, 4'd3);
    @(posedge clk); #1;
    check("hs_p_a", p3, 8'd7);
    check("hs_v_a", {7'b0, valid3}, 8'd1);
    drive(1'b0, 4'd15, 4'd15);
    @(posedge clk); #1;
    check("hs_p_hold", p3, 8'd7);
    check("hs_v_idle", {7'b0, valid3}, 8'd0);
    drive(1'b1, 4'd15, 4'd15);
    @(posedge clk); #1;
    check("hs_p_b", p3, 8'd215);
    check("hs_v_b", {7'b0, valid3}, 8'd1);

    // Randomized traffic with random bubbles
    for (int n = 0; n < 300; n++)
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Mid-stream reset discards the in-flight result
    drive(1'b1, 4'd9, 4'd9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_p3", p3, 8'd0);
    check("async_rst_valid3", {7'b0, valid3}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_async_p3", p3, 8'd0);
    check("post_async_valid3", {7'b0, valid3}, 8'd0);

    // Full back-to-back sweep of all operand pairs
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      sweep_on = 1'b1;
      in_valid = 1'b1;
      A = 4'(c >> 4);
      B = 4'(c);
    end
    @(negedge clk);
    sweep_on = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("sweep_count", 8'(sweep_cnt == 256), 8'd1);
    check("mre_exact_zero", 8'(err0 == 0.0), 8'd1);
    check("mre_approx_nonzero", 8'(err3 > 0.0), 8'd1);
    $display("Mean relative error APPROX_COLS=3: %0.2f%%", err3 / 256.0 * 100.0);
    $display("Mean relative error APPROX_COLS=0: %0.2f%%", err0 / 256.0 * 100.0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
